// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word field positions, PC-select encodings,
// the NOP encoding and the fetch FSM state type.
package cpu_pkg;

   localparam int CW_PS_HI = 28;
   localparam int CW_PS_LO = 27;
   localparam int CW_PCSEL = 26;
   localparam int CW_IL    = 24;
   localparam int CW_SL    = 23;

   localparam logic [1:0] PS_HOLD   = 2'b00;
   localparam logic [1:0] PS_INC    = 2'b01;
   localparam logic [1:0] PS_BRANCH = 2'b10;
   localparam logic [1:0] PS_HOLD2  = 2'b11;

   localparam logic [31:0] NOP_INSTR = 32'hD503201F;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/RegisterNbit.sv
// N-bit register with load enable; one-cycle latency, holds when load is low.
// Asynchronous active-high reset clears to zero.
module RegisterNbit #(
   parameter int N = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/pc_next.sv
// Combinational next-PC selection: hold, increment by 4, PC-relative word
// branch or absolute register target. All arithmetic wraps modulo 2^64.
module pc_next
   import cpu_pkg::*;
(
   input  logic [63:0] pc,
   input  logic [1:0]  ps,
   input  logic        pcsel,
   input  logic [63:0] k,
   input  logic [63:0] reg_a,
   output logic [63:0] next_pc
);

   always_comb begin
      next_pc = pc;
      case (ps)
         PS_INC:    next_pc = pc + 64'd4;
         // k is a word offset; register targets are taken unaligned as-is
         PS_BRANCH: next_pc = pcsel ? (pc + (k << 2)) : reg_a;
         default:   next_pc = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, instruction and status registers plus a two-state
// memory handshake FSM; stall freezes the control unit while a fetch is pending.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  cw_ps,
   input  logic        cw_pcsel,
   input  logic        cw_il,
   input  logic        cw_sl,
   input  logic [63:0] k,
   input  logic [63:0] reg_a,
   input  logic [3:0]  alu_status,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [63:0] pc,
   output logic [31:0] instruction,
   output logic [3:0]  status,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   output logic        stall,
   output logic        fetch_fault
);

   localparam logic [3:0] TIMEOUT_CNT = TIMEOUT[3:0];

   fetch_state_t state, state_next;
   logic [3:0]   timer, timer_next, timer_inc;
   logic         instr_load;
   logic [31:0]  instr_next;
   logic         fault_set;
   logic [63:0]  pc_nxt;

   assign imem_req  = (state == WAIT);
   assign imem_addr = pc;
   assign timer_inc = timer + 4'd1;

   always_comb begin
      state_next = state;
      timer_next = timer;
      instr_load = 1'b0;
      instr_next = imem_rdata;
      fault_set  = 1'b0;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (cw_il) begin
               state_next = WAIT;
               stall      = 1'b1;
            end
         end
         WAIT: begin
            // ready wins over a coincident timeout
            if (imem_ready) begin
               instr_load = 1'b1;
               state_next = IDLE;
               timer_next = 4'd0;
            end else begin
               stall = 1'b1;
               if (timer_inc == TIMEOUT_CNT) begin
                  instr_load = 1'b1;
                  instr_next = NOP_INSTR;
                  fault_set  = 1'b1;
                  state_next = IDLE;
                  timer_next = 4'd0;
               end else begin
                  timer_next = timer_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         timer       <= 4'd0;
         instruction <= 32'd0;
         fetch_fault <= 1'b0;
         pc          <= 64'd0;
      end else begin
         state <= state_next;
         timer <= timer_next;
         if (instr_load)
            instruction <= instr_next;
         if (fault_set)
            fetch_fault <= 1'b1;
         if (!stall)
            pc <= pc_nxt;
      end
   end

   pc_next u_pc_next (
      .pc      (pc),
      .ps      (cw_ps),
      .pcsel   (cw_pcsel),
      .k       (k),
      .reg_a   (reg_a),
      .next_pc (pc_nxt)
   );

   RegisterNbit #(.N(4)) u_status (
      .clock (clock),
      .reset (reset),
      .load  (cw_sl & ~stall),
      .d     (alu_status),
      .q     (status)
   );

endmodule
